// File: rtl/imem_loader.sv
// Program loader: receives a byte stream (count byte, then little-endian words),
// writes the words to instruction memory from address 0 and holds the core in reset until done.
module imem_loader #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              cpu_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int MAX_WORDS = 1 << ADDR_W;
    localparam int CNT_W     = ADDR_W + 1;
    localparam int TMO_W     = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_BYTE,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]    n_words_q, n_words_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                accept;
    logic                count_bad;
    logic                tmo_hit;

    assign rx_ready_o = (state_q == S_COUNT) || (state_q == S_BYTE);
    assign accept     = rx_valid_i && rx_ready_o;
    // A count of zero or above the memory depth can never describe a valid program.
    assign count_bad  = (rx_data_i == 8'd0) || ({1'b0, rx_data_i} > 9'(MAX_WORDS));
    assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            word_cnt_q <= '0;
            n_words_q  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_cnt_q <= word_cnt_d;
            n_words_q  <= n_words_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_cnt_d = word_cnt_q;
        n_words_d  = n_words_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tmo_d      = tmo_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_i) begin
                    state_d    = S_COUNT;
                    byte_idx_d = '0;
                    word_cnt_d = '0;
                    addr_d     = '0;
                    tmo_d      = '0;
                end
            end
            S_COUNT: begin
                if (accept) begin
                    tmo_d = '0;
                    if (count_bad) begin
                        state_d = S_ERR;
                    end else begin
                        n_words_d = rx_data_i[CNT_W-1:0];
                        state_d   = S_BYTE;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_BYTE: begin
                if (accept) begin
                    tmo_d                          = '0;
                    data_d[{byte_idx_q, 3'b000} +: 8] = rx_data_i;
                    byte_idx_d                     = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WRITE: begin
                // The word counter, not the (possibly wrapping) address, ends the load.
                addr_d     = addr_q + 1'b1;
                word_cnt_d = word_cnt_q + 1'b1;
                byte_idx_d = '0;
                tmo_d      = '0;
                if (word_cnt_q + 1'b1 == n_words_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BYTE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_we_o   = (state_q == S_WRITE);
    assign imem_addr_o = addr_q;
    assign imem_data_o = data_q;
    assign cpu_rst_no  = (state_q == S_DONE);
    assign busy_o      = (state_q == S_COUNT) || (state_q == S_BYTE) || (state_q == S_WRITE);
    assign done_o      = (state_q == S_DONE);
    assign error_o     = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random byte streams against a stream-level model of
// count/word parsing, timeout and the expected instruction-memory image.
module tb_imem_loader;

    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .load_i      (load),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .rx_ready_o  (rx_ready),
        .imem_we_o   (imem_we),
        .imem_addr_o (imem_addr),
        .imem_data_o (imem_data),
        .cpu_rst_no  (cpu_rst_n),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        int                c;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] mem_dut [DEPTH] = '{default: '0};
    logic [31:0] exp_mem [DEPTH] = '{default: '0};
    logic [31:0] prog [DEPTH];
    int          n_writes = 0;

    // Stream-level reference: phase 0 = not loading, 1 = awaiting count, 2 = receiving words
    int                m_phase = 0;
    int                m_left = 0;
    int                m_k = 0;
    int                m_idle = 0;
    bit                m_skip = 0;
    bit                m_done = 0;
    bit                m_err = 0;
    logic [31:0]       m_word = '0;
    logic [ADDR_W-1:0] m_addr = '0;

    task automatic monitor_loop();
        wr_t        e;
        logic [5:0] exp_st;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = 0; m_skip = 0; m_done = 0; m_err = 0;
                exp_q.delete();
            end else begin
                exp_st = {(m_phase != 0) && !m_skip, m_phase != 0, (m_phase == 0) && m_done,
                          (m_phase == 0) && m_err, (m_phase == 0) && m_done, m_skip};
                chk("status", {rx_ready, busy, done, error, cpu_rst_n, imem_we}, exp_st);
                if (imem_we) begin
                    n_writes++;
                    mem_dut[imem_addr] = imem_data;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_we", imem_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", imem_addr, e.a);
                        chk("wr_data", imem_data, e.d);
                        chk("wr_cycle", cyc, e.c);
                    end
                end
                if (m_phase == 0) begin
                    if (load) begin
                        m_phase = 1; m_addr = '0; m_idle = 0; m_done = 0; m_err = 0;
                    end
                end else if (m_skip) begin
                    m_skip = 0;
                    if (m_left == 0) begin
                        m_phase = 0; m_done = 1;
                    end
                end else if (rx_valid) begin
                    m_idle = 0;
                    if (m_phase == 1) begin
                        if (rx_data == 0 || int'(rx_data) > DEPTH) begin
                            m_phase = 0; m_err = 1;
                        end else begin
                            m_left = int'(rx_data); m_phase = 2; m_k = 0; m_word = '0;
                        end
                    end else begin
                        m_word = m_word | (32'(rx_data) << (8 * m_k));
                        m_k++;
                        if (m_k == 4) begin
                            exp_q.push_back('{a: m_addr, d: m_word, c: cyc + 1});
                            exp_mem[m_addr] = m_word;
                            m_addr = m_addr + 1'b1;
                            m_left--;
                            m_k = 0;
                            m_word = '0;
                            m_skip = 1;
                        end
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_phase = 0; m_err = 1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        bit ok = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!ok && n < 64) begin
            @(negedge clk);
            ok = rx_ready;
            tick();
            n++;
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (!ok) chk("accept_bound", 0, 1);
        repeat (gap) tick();
    endtask

    // gap < 0 selects a random 0..4 idle cycles after each byte
    task automatic send_words(input int n, input int gap);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = prog[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], (gap < 0) ? int'($urandom_range(0, 4)) : gap);
            end
        end
    endtask

    task automatic wait_outcome(input bit ok);
        int i = 0;
        int bad = 0;
        while (!(done || error) && i < 4 * TIMEOUT) begin
            tick();
            i++;
        end
        chk("outcome_bound", i < 4 * TIMEOUT, 1);
        chk("done", done, ok);
        chk("error", error, !ok);
        chk("cpu_rst_n", cpu_rst_n, ok);
        chk("pending_writes", exp_q.size(), 0);
        for (int k = 0; k < DEPTH; k++) begin
            if (mem_dut[k] !== exp_mem[k]) bad++;
        end
        chk("mem_contents", bad, 0);
    endtask

    task automatic load_prog(input int n, input int gap);
        start_load();
        send_byte(8'(n), gap < 0 ? 0 : gap);
        send_words(n, gap);
        wait_outcome(1);
    endtask

    int w0;
    int first;
    int nrand;

    initial begin
        fork
            monitor_loop();
        join_none

        #12;
        chk("reset_outputs", {rx_ready, imem_we, imem_addr, imem_data, cpu_rst_n, busy, done, error}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) tick();

        prog[0] = 32'h0050_0013;
        prog[1] = 32'h0010_0093;
        load_prog(2, 0);
        chk("addr_after_two", imem_addr, 2);
        load_prog(2, 3);

        w0 = n_writes;
        start_load();
        send_byte(8'h00, 0);
        wait_outcome(0);
        start_load();
        send_byte(8'h41, 0);
        wait_outcome(0);
        chk("badcount_no_write", n_writes, w0);

        start_load();
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        first = 0;
        for (int i = 1; i <= TIMEOUT + 4; i++) begin
            tick();
            if (error && first == 0) first = i;
        end
        chk("timeout_cycles", first, TIMEOUT);
        chk("timeout_no_write", n_writes, w0);
        for (int i = 0; i < 3; i++) prog[i] = $urandom;
        load_prog(3, -1);

        for (int r = 0; r < 4; r++) begin
            nrand = $urandom_range(1, 8);
            for (int i = 0; i < nrand; i++) prog[i] = $urandom;
            load_prog(nrand, -1);
        end

        for (int i = 0; i < DEPTH; i++) prog[i] = i;
        load_prog(DEPTH, -1);
        chk("addr_wrap", imem_addr, 0);
        load = 1'b1;
        chk("reload_hold_run", cpu_rst_n, 1);
        tick();
        load = 1'b0;
        chk("reload_cpu_rst", cpu_rst_n, 0);
        chk("reload_busy", busy, 1);
        prog[0] = 32'hDEAD_BEEF;
        send_byte(8'h01, 0);
        send_words(1, 0);
        wait_outcome(1);
        chk("reload_word0", mem_dut[0], 32'hDEAD_BEEF);
        chk("reload_word1", mem_dut[1], 1);

        prog[0] = $urandom;
        prog[1] = 32'h1122_3344;
        start_load();
        send_byte(8'h02, 0);
        send_words(1, 0);
        send_byte(8'h44, 0);
        send_byte(8'h33, 0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {rx_ready, imem_we, imem_addr, imem_data, cpu_rst_n, busy, done, error}, 0);
        w0 = n_writes;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("reset_no_write", n_writes, w0);
        chk("reset_idle", {busy, done, error, cpu_rst_n}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
